// File: rtl/edge_mask_gen.sv
// Streaming edge-mask generator: luma gradient against the pixel to the left and the one above,
// thresholded to an 8-bit mask, with the RGB pixel delayed 2 cycles to stay aligned.
// Optional macro EDGE_MASK_DILATE_EN adds 1-pixel horizontal dilation of the mask.
module edge_mask_gen #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter logic [7:0]  EDGE_VAL = 8'd255
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iDVAL,
  input  logic       iSOF,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  input  logic [8:0] iTHRESH,
  output logic       oDVAL,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB,
  output logic [7:0] oGray
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  // position of the next accepted pixel, and luma of the last accepted pixel
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [7:0]       prev_y;

  // previous line's luma; content before the first full line is masked by row-0 gating
  logic [7:0] line_buf [IMG_W];

  // stage 1 registers
  logic             s1_vld;
  logic [7:0]       s1_r;
  logic [7:0]       s1_g;
  logic [7:0]       s1_b;
  logic [7:0]       s1_y;
  logic [7:0]       s1_prev_y;
  logic [7:0]       s1_lb_y;
  logic             s1_col0;
  logic             s1_row0;

  // stage 1 combinational
  logic [7:0]       y_c;
  logic [COL_W-1:0] col_c;
  logic [ROW_W-1:0] row_c;
  logic [COL_W-1:0] col_next_c;
  logic [ROW_W-1:0] row_next_c;

  always_comb begin
    y_c        = 8'(({2'b00, iR} + {1'b0, iG, 1'b0} + {2'b00, iB}) >> 2);
    col_c      = iSOF ? '0 : col;
    row_c      = iSOF ? '0 : row;
    col_next_c = col_c + COL_W'(1);
    row_next_c = row_c;
    if (col_c == COL_LAST) begin
      col_next_c = '0;
      row_next_c = (row_c == ROW_LAST) ? '0 : row_c + ROW_W'(1);
    end
  end

  // position counters and left-neighbour luma advance only on accepted pixels
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col    <= '0;
      row    <= '0;
      prev_y <= 8'd0;
    end else if (iDVAL) begin
      col    <= col_next_c;
      row    <= row_next_c;
      prev_y <= y_c;
    end
  end

  // read-before-write: the old entry is the luma directly above this pixel
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      s1_lb_y         <= line_buf[col_c];
      line_buf[col_c] <= y_c;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1_vld    <= 1'b0;
      s1_r      <= 8'd0;
      s1_g      <= 8'd0;
      s1_b      <= 8'd0;
      s1_y      <= 8'd0;
      s1_prev_y <= 8'd0;
      s1_col0   <= 1'b0;
      s1_row0   <= 1'b0;
    end else begin
      s1_vld <= iDVAL;
      if (iDVAL) begin
        s1_r      <= iR;
        s1_g      <= iG;
        s1_b      <= iB;
        s1_y      <= y_c;
        s1_prev_y <= prev_y;
        s1_col0   <= (col_c == '0);
        s1_row0   <= (row_c == '0);
      end
    end
  end

  // stage 2 combinational: gradient and threshold
  logic [7:0] hgrad_c;
  logic [7:0] vgrad_c;
  logic [8:0] grad_c;
  logic       raw_edge_c;
  logic       is_edge_c;

  always_comb begin
    hgrad_c = 8'd0;
    vgrad_c = 8'd0;
    if (!s1_col0) begin
      hgrad_c = (s1_y > s1_prev_y) ? (s1_y - s1_prev_y) : (s1_prev_y - s1_y);
    end
    if (!s1_row0) begin
      vgrad_c = (s1_y > s1_lb_y) ? (s1_y - s1_lb_y) : (s1_lb_y - s1_y);
    end
    grad_c     = 9'(hgrad_c) + 9'(vgrad_c);
    raw_edge_c = (grad_c > iTHRESH);
  end

`ifdef EDGE_MASK_DILATE_EN
  // raw compare of the previous output pixel; dilation never chains
  logic prev_raw;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      prev_raw <= 1'b0;
    end else if (s1_vld) begin
      prev_raw <= raw_edge_c;
    end
  end

  assign is_edge_c = raw_edge_c | (prev_raw & ~s1_col0);
`else
  assign is_edge_c = raw_edge_c;
`endif

  // output stage: data holds while oDVAL is low
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL <= 1'b0;
      oR    <= 8'd0;
      oG    <= 8'd0;
      oB    <= 8'd0;
      oGray <= 8'd0;
    end else begin
      oDVAL <= s1_vld;
      if (s1_vld) begin
        oR    <= s1_r;
        oG    <= s1_g;
        oB    <= s1_b;
        oGray <= is_edge_c ? EDGE_VAL : 8'd0;
      end
    end
  end

endmodule
